window3x3_gen: RTL

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

---
 rtl/img_pkg.sv | 42 ++++
 rtl/linebuf.sv | 41 ++++
 rtl/window3x3_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
`default_nettype none
//==============================================================================
// Module      : img_pkg
// Description : Shared image-pipeline types and helpers. Provides the 8-bit
//               grey pixel type, the 3x3 window structure, the window
//               generator state encoding and a clog2-based counter-width
//               function. Used by window3x3_gen, linebuf and gaussian3x3.
// Revision    : 1.0 - initial release
//==============================================================================
package img_pkg;

    localparam int unsigned c_PIX_W = 8;

    typedef logic [c_PIX_W-1:0] pixel_t;

    // pRC = row R, column C; row 0 is the oldest line, column 0 the oldest
    // pixel, so p22 is always the most recently accepted pixel.
    typedef struct packed {
        pixel_t p00;
        pixel_t p01;
        pixel_t p02;
        pixel_t p10;
        pixel_t p11;
        pixel_t p12;
        pixel_t p20;
        pixel_t p21;
        pixel_t p22;
    } window_t;

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_ACTIVE   = 2'd1,
        S_DONE     = 2'd2
    } win_state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : img_pkg
`default_nettype wire

// File: rtl/linebuf.sv
`default_nettype none
//==============================================================================
// Module      : linebuf
// Description : Single-port line memory holding one image line of pixels.
//               Combinational read, synchronous write, contents not reset.
// Ports       : clk     - rising-edge clock
//               i_we    - write enable
//               i_addr  - read/write address (pixel column)
//               i_wdata - write data
//               o_rdata - read data at i_addr (value before any write this
//                         cycle)
// Revision    : 1.0 - initial release
//==============================================================================
module linebuf
    import img_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = int'(cnt_width(DEPTH))
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  pixel_t        i_wdata,
    output pixel_t        o_rdata
);

    pixel_t r_mem [DEPTH];

    // Read is asynchronous so a read and a write to the same address in one
    // cycle return the old contents; the window generator relies on this to
    // shift a column down through both buffers in a single cycle.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule : linebuf
`default_nettype wire

// File: rtl/window3x3_gen.sv
`default_nettype none
//==============================================================================
// Module      : window3x3_gen
// Description : Raster-order 3x3 sliding-window generator. Two line buffers
//               hold the previous two lines; each accepted pixel shifts a new
//               column into the window. A window is flagged valid only when
//               it lies fully inside the frame (no border windows).
// Optional    : define WINDOW3X3_EOF_EN to add the eof output, pulsed with the
//               final window of a frame.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               sof        - start of frame, qualified by pix_valid
//               pix_valid  - pix_in carries a pixel this cycle
//               pix_in     - raster-order grey pixel
//               p00..p22   - 3x3 window, pRC = row R column C, p22 newest
//               win_valid  - window outputs valid this cycle
//               eof        - (WINDOW3X3_EOF_EN) last window of the frame
// Revision    : 1.0 - initial release
//==============================================================================
module window3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sof,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    output logic [7:0] p00,
    output logic [7:0] p01,
    output logic [7:0] p02,
    output logic [7:0] p10,
    output logic [7:0] p11,
    output logic [7:0] p12,
    output logic [7:0] p20,
    output logic [7:0] p21,
    output logic [7:0] p22,
`ifdef WINDOW3X3_EOF_EN
    output logic       eof,
`endif
    output logic       win_valid
);

    localparam int c_CW = int'(cnt_width(IMG_W));
    localparam int c_RW = int'(cnt_width(IMG_H));

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);
    localparam logic [c_CW-1:0] c_COL_ONE  = c_CW'(1);
    localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);

    win_state_t      r_state;
    win_state_t      w_state_nxt;
    logic [c_CW-1:0] r_col;
    logic [c_CW-1:0] w_col_cur;
    logic [c_CW-1:0] w_col_nxt;
    logic [c_RW-1:0] r_row;
    logic [c_RW-1:0] w_row_cur;
    logic [c_RW-1:0] w_row_nxt;
    logic            w_restart;
    logic            w_accept;
    logic            w_last;
    logic            w_win_hit;
    pixel_t          w_lb0_rd;
    pixel_t          w_lb1_rd;
    window_t         r_win;
    logic            r_win_valid;

    //--------------------------------------------------------------------------
    // Pixel acceptance and position of the pixel being accepted.
    // A sof pixel is always (0,0), whatever the counters currently say, so
    // the effective position is overridden before it addresses the buffers.
    //--------------------------------------------------------------------------
    always_comb begin
        w_restart = pix_valid && sof;
        w_accept  = w_restart || (pix_valid && (r_state == S_ACTIVE));
        w_col_cur = w_restart ? '0 : r_col;
        w_row_cur = w_restart ? '0 : r_row;
        w_last    = (w_col_cur == c_COL_LAST) && (w_row_cur == c_ROW_LAST);
        w_win_hit = w_accept && (w_col_cur >= c_COL_TWO) && (w_row_cur >= c_ROW_TWO);
    end

    //--------------------------------------------------------------------------
    // Next column/row counters.
    //--------------------------------------------------------------------------
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_accept) begin
            if (w_col_cur == c_COL_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = (w_row_cur == c_ROW_LAST) ? '0 : (w_row_cur + c_ROW_ONE);
            end else begin
                w_col_nxt = w_col_cur + c_COL_ONE;
                w_row_nxt = w_row_cur;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Frame FSM: next state
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_restart) begin
            w_state_nxt = S_ACTIVE;
        end else if (w_accept && w_last) begin
            // w_accept without sof is only possible in S_ACTIVE
            w_state_nxt = S_DONE;
        end
    end

    //--------------------------------------------------------------------------
    // Frame FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Counters, window shift register and valid flag
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win       <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_win_valid <= w_win_hit;
            if (w_accept) begin
                // Shift left; the new right column is the same image column
                // from two lines ago, one line ago and the current line.
                r_win.p00 <= r_win.p01;
                r_win.p01 <= r_win.p02;
                r_win.p02 <= w_lb1_rd;
                r_win.p10 <= r_win.p11;
                r_win.p11 <= r_win.p12;
                r_win.p12 <= w_lb0_rd;
                r_win.p20 <= r_win.p21;
                r_win.p21 <= r_win.p22;
                r_win.p22 <= pix_in;
            end
        end
    end

`ifdef WINDOW3X3_EOF_EN
    logic r_eof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eof <= 1'b0;
        end else begin
            r_eof <= w_win_hit && w_last;
        end
    end

    assign eof = r_eof;
`endif

    //--------------------------------------------------------------------------
    // Line buffers: lb0 holds the previous line, lb1 the line before it.
    // Each accepted pixel moves lb0[col] down into lb1[col] and stores the
    // new pixel in lb0[col].
    //--------------------------------------------------------------------------
    linebuf #(
        .DEPTH (IMG_W),
        .AW    (c_CW)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col_cur),
        .i_wdata (pix_in),
        .o_rdata (w_lb0_rd)
    );

    linebuf #(
        .DEPTH (IMG_W),
        .AW    (c_CW)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col_cur),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    assign p00       = r_win.p00;
    assign p01       = r_win.p01;
    assign p02       = r_win.p02;
    assign p10       = r_win.p10;
    assign p11       = r_win.p11;
    assign p12       = r_win.p12;
    assign p20       = r_win.p20;
    assign p21       = r_win.p21;
    assign p22       = r_win.p22;
    assign win_valid = r_win_valid;

endmodule : window3x3_gen
`default_nettype wire
